// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between pipeline writeback (A) and a
// long-latency unit (B). B gets forced priority after waiting STARVE_LIMIT cycles.
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit,
    output logic        force_b
);

    typedef enum logic {PRIO_A, FORCE_B} state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    state_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            a_xfer, b_xfer, wr_acc;
    wr_req_t         win;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= PRIO_A;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Readies depend only on state and a_valid, never on the B inputs.
    always_comb begin
        state_nxt = state;
        a_ready   = 1'b1;
        b_ready   = ~a_valid;
        force_b   = 1'b0;
        if (state == FORCE_B) begin
            a_ready = 1'b0;
            b_ready = 1'b1;
            force_b = 1'b1;
        end
        a_xfer = a_valid & a_ready;
        b_xfer = b_valid & b_ready;

        cnt_nxt = cnt;
        if (b_xfer || !b_valid)
            cnt_nxt = '0;
        else if (cnt != {CNT_W{1'b1}})
            cnt_nxt = cnt + 1'b1;

        case (state)
            PRIO_A: if (b_valid && !b_ready && cnt == CNT_W'(STARVE_LIMIT - 1))
                        state_nxt = FORCE_B;
            // A dropped b_valid also releases the force; nothing is written then.
            FORCE_B: if (b_xfer || !b_valid)
                        state_nxt = PRIO_A;
            default: state_nxt = PRIO_A;
        endcase
    end

    assign wr_acc = a_xfer | b_xfer;
    assign win    = a_xfer ? wr_req_t'{addr: a_addr, data: a_data}
                           : wr_req_t'{addr: b_addr, data: b_data};

    // r0 writes complete the handshake but never raise the enable.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rf_we <= 1'b0;
            rf_wn <= '0;
            rf_d  <= '0;
        end else if (wr_acc) begin
            rf_we <= (win.addr != 5'd0);
            rf_wn <= win.addr;
            rf_d  <= win.data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    assign chk_hit = rf_we & (rf_wn == chk_addr) & (chk_addr != 5'd0);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized scoreboard bench for regfile_wr_arbiter: driver predicts grants from
// a wait-count model and queues expected writes; a negedge monitor checks the port.
module tb_regfile_wr_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, chk_addr;
    logic [31:0] a_data, b_data;
    logic        rf_we, chk_hit, force_b;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;

    regfile_wr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk(clk), .clrn(clrn),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .force_b(force_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 0;
    int          b_wait = 0;
    logic        b_v = 0;
    logic [4:0]  b_a = 0;
    logic [31:0] b_d = 0;
    logic [4:0]  last_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; B request comes from b_v/b_a/b_d and is held until granted.
    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] ca);
        bit   forced, a_win, b_win;
        wr_t  e;
        @(posedge clk); #1;
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = b_v; b_addr = b_a; b_data = b_d;
        chk_addr = ca;
        forced = (b_wait >= STARVE_LIMIT);
        #1;
        check("a_ready", a_ready, !forced);
        check("b_ready", b_ready, forced || !av);
        check("force_b", force_b, forced);
        a_win = av && !forced;
        b_win = b_v && !a_win;
        if (a_win || b_win) begin
            e.cyc  = cyc + 1;
            e.addr = a_win ? aa : b_a;
            e.data = a_win ? ad : b_d;
            e.we   = (e.addr != 0);
            q.push_back(e);
            last_addr = e.addr;
        end
        b_wait = (!b_v || b_win) ? 0 : b_wait + 1;
        if (b_win) b_v = 0;
    endtask

    // Monitor: port state for the current cycle, including held wn/d when idle.
    logic        exp_we = 0;
    logic [4:0]  exp_wn = 0;
    logic [31:0] exp_d = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                wr_t e;
                e = q.pop_front();
                exp_we = e.we; exp_wn = e.addr; exp_d = e.data;
            end else begin
                exp_we = 0;
            end
            check("rf_we", rf_we, exp_we);
            check("rf_wn", rf_wn, exp_wn);
            check("rf_d", rf_d, exp_d);
            check("chk_hit", chk_hit, exp_we && exp_wn == chk_addr && chk_addr != 0);
        end
    end

    initial begin
        clrn = 0; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0; chk_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        clrn = 1;
        #1;
        check("rst rf_we", rf_we, 0);
        check("rst rf_wn", rf_wn, 0);
        check("rst rf_d", rf_d, 0);
        check("rst a_ready", a_ready, 1);
        check("rst b_ready", b_ready, 1);
        check("rst force_b", force_b, 0);
        mon_en = 1;

        // A only, then idle
        step(1, 5'd3, 32'd123, 5'd0);
        step(0, 5'd0, 32'd0, 5'd3);
        step(0, 5'd0, 32'd0, 5'd3);
        // A and B together: A first, B next
        b_v = 1; b_a = 5'd4; b_d = 32'd456;
        step(1, 5'd1, 32'd6, 5'd0);
        step(0, 5'd0, 32'd0, 5'd1);
        step(0, 5'd0, 32'd0, 5'd4);
        // Starvation: A every cycle, B forced on the fifth
        b_v = 1; b_a = 5'd2; b_d = 32'd5;
        for (int i = 0; i < 7; i++) step(1, 5'(i + 8), 32'(100 + i), 5'(i + 7));
        // r0 write from A
        step(1, 5'd0, 32'd4, 5'd0);
        step(0, 5'd0, 32'd0, 5'd0);

        for (int i = 0; i < 400; i++) begin
            logic av;
            logic [4:0] ca;
            av = ($urandom % 4) != 0;
            if (!b_v && ($urandom % 3) == 0) begin
                b_v = 1; b_a = 5'($urandom); b_d = $urandom;
            end
            ca = ($urandom % 2) ? last_addr : 5'($urandom);
            step(av, 5'($urandom), $urandom, ca);
        end
        while (b_v) step(0, 5'd0, 32'd0, 5'd0);
        step(0, 5'd0, 32'd0, 5'd0);

        // Hazard then mid-write reset
        b_v = 1; b_a = 5'd10; b_d = 32'h5;
        step(0, 5'd0, 32'd0, 5'd0);
        mon_en = 0;
        @(posedge clk); #1;
        b_valid = 0; a_valid = 0;
        chk_addr = 5'd10; #1;
        check("hz rf_we", rf_we, 1);
        check("hz rf_wn", rf_wn, 10);
        check("hz rf_d", rf_d, 32'h5);
        check("hz hit10", chk_hit, 1);
        chk_addr = 5'd11; #1;
        check("hz hit11", chk_hit, 0);
        chk_addr = 5'd10;
        clrn = 0; #1;
        check("mid rst rf_we", rf_we, 0);
        check("mid rst chk_hit", chk_hit, 0);
        check("mid rst force_b", force_b, 0);
        check("mid rst rf_wn", rf_wn, 0);
        q.delete();
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
